// File: rtl/fetch_unit_wide.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_wide
// Description : Multi-lane instruction fetch. Reads FETCH_WIDTH consecutive
//               big-endian 32-bit instructions per cycle from an internal
//               byte-addressed memory and hands them to decode as one bundle
//               over a valid/ready handshake. Supports backpressure, redirect
//               with flush, a byte-wide memory load port and done status.
// Options     : define FETCH_PERF_CNT_EN to add saturating performance
//               counters (perf_bundles, perf_stall_cycles, perf_flushes).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_wide #(
  parameter int FETCH_WIDTH = 2,
  parameter int MEM_BYTES   = 1024,
  parameter int PC_BITS     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  total_instructions,
  input  logic                         start,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] mem_wr_addr,
  input  logic [7:0]                   mem_wr_data,
  input  logic                         redirect_valid,
  input  logic [PC_BITS-1:0]           redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [32*FETCH_WIDTH-1:0]    out_instr,
  output logic [FETCH_WIDTH-1:0]       out_lane_valid,
  output logic [PC_BITS-1:0]           out_pc,
  output logic                         done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_bundles,
  output logic [31:0]                  perf_stall_cycles,
  output logic [15:0]                  perf_flushes
`endif
);

  localparam int ADDR_BITS = $clog2(MEM_BYTES);
  // Limit and lane PCs carry two extra bits so total*4 never overflows.
  localparam int LIM_BITS  = PC_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [PC_BITS-1:0]          pc;
  logic [7:0]                  mem [MEM_BYTES];

  logic [LIM_BITS-1:0]         limit;
  logic [LIM_BITS-1:0]         pc_ext;
  logic [PC_BITS-1:0]          redirect_target;
  logic                        slot_free;
  logic                        can_fetch;
  logic                        fetch_now;
  logic                        exhaust;
  logic [32*FETCH_WIDTH-1:0]   bundle_instr;
  logic [FETCH_WIDTH-1:0]      bundle_lanes;

  assign limit           = LIM_BITS'({total_instructions, 2'b00});
  assign pc_ext          = {2'b00, pc};
  assign redirect_target = redirect_pc & ~PC_BITS'(3);
  assign slot_free       = !out_valid || out_ready;
  assign can_fetch       = pc_ext < limit;
  assign fetch_now       = (state == ST_FETCH) && slot_free && can_fetch;
  assign exhaust         = (state == ST_FETCH) && slot_free && !can_fetch;

  // Per-lane address generation; memory addresses wrap modulo MEM_BYTES.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    logic [LIM_BITS-1:0]  lane_pc;
    logic [ADDR_BITS-1:0] lane_addr;
    assign lane_pc         = pc_ext + LIM_BITS'(4 * i);
    assign lane_addr       = pc[ADDR_BITS-1:0] + ADDR_BITS'(4 * i);
    assign bundle_lanes[i] = lane_pc < limit;
    assign bundle_instr[32*i +: 32] = bundle_lanes[i] ?
        {mem[lane_addr],
         mem[lane_addr + ADDR_BITS'(1)],
         mem[lane_addr + ADDR_BITS'(2)],
         mem[lane_addr + ADDR_BITS'(3)]} : 32'h0;
  end

  // Synchronous byte write port; a same-cycle fetch sees the old byte.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; redirect overrides every other transition.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = ST_FETCH;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_next = ST_FETCH;
        ST_FETCH: if (exhaust) state_next = ST_DONE;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // PC, output slot and done flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= '0;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_lane_valid <= '0;
      out_pc         <= '0;
      done           <= 1'b0;
    end else if (redirect_valid) begin
      pc             <= redirect_target;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_lane_valid <= '0;
      done           <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        pc <= '0;
      end
      if (fetch_now) begin
        out_valid      <= 1'b1;
        out_instr      <= bundle_instr;
        out_lane_valid <= bundle_lanes;
        out_pc         <= pc;
        pc             <= pc + PC_BITS'(4 * FETCH_WIDTH);
      end else if (exhaust) begin
        out_valid      <= 1'b0;
        out_instr      <= '0;
        out_lane_valid <= '0;
        done           <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters, cleared by reset and an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_bundles      <= '0;
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else if (state == ST_IDLE && start && !redirect_valid) begin
      perf_bundles      <= '0;
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (out_valid && out_ready && perf_bundles != '1) begin
        perf_bundles <= perf_bundles + 32'd1;
      end
      if (out_valid && !out_ready && perf_stall_cycles != '1) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (redirect_valid && out_valid && perf_flushes != '1) begin
        perf_flushes <= perf_flushes + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
